// File: rtl/adrv9001_gpio_in_capture_if.sv
// adrv9001_gpio_in_capture_if: pad inputs, PS GPIO buses, edge masks and status/interrupt outputs of the GPIO input capture block.
interface adrv9001_gpio_in_capture_if;
    logic [11:0] dgpio_in;
    logic        irq_in;
    logic [17:0] gpio_tri_o;
    logic [17:0] gpio_tri_i;
    logic [12:0] rise_mask;
    logic [12:0] fall_mask;
    logic [12:0] status_clr;
    logic [12:0] status;
    logic        irq;
    logic [31:0] ts_first;
    modport master (
        output dgpio_in, irq_in, gpio_tri_o, rise_mask, fall_mask, status_clr,
        input  gpio_tri_i, status, irq, ts_first
    );
    modport slave (
        input  dgpio_in, irq_in, gpio_tri_o, rise_mask, fall_mask, status_clr,
        output gpio_tri_i, status, irq, ts_first
    );
endinterface

// File: rtl/adrv9001_gpio_in_capture.sv
// adrv9001_gpio_in_capture: synchronizes and debounces DGPIO/IRQ pads, latches masked edges into W1C status with a level irq.
// Optional PIN_IRQ_TIMESTAMP_EN adds a free-running counter that stamps the first event into ts_first.
module adrv9001_gpio_in_capture #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    adrv9001_gpio_in_capture_if.slave bus
);
    localparam int N     = 13;
    localparam int CNT_W = DEBOUNCE_CYCLES < 1 ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0] pad, syn, filt, filt_d, rise, fall, status_q, status_nxt;
    logic         irq_q;

    assign pad = {bus.irq_in, bus.dgpio_in};
    assign syn = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign filt = syn;
    end else begin : g_debounce
        logic [N-1:0][CNT_W-1:0] cnt;
        // cnt counts consecutive synced cycles that disagree with filt; it is cleared before it can reach DEBOUNCE_CYCLES
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                filt <= '0;
            end else begin
                for (int b = 0; b < N; b++) begin
                    if (syn[b] == filt[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        filt[b] <= syn[b];
                        cnt[b]  <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    assign rise       = filt & ~filt_d & bus.rise_mask;
    assign fall       = ~filt & filt_d & bus.fall_mask;
    assign status_nxt = (status_q & ~bus.status_clr) | rise | fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            filt_d   <= filt;
            status_q <= status_nxt;
            irq_q    <= |status_q;
        end
    end

`ifdef PIN_IRQ_TIMESTAMP_EN
    logic [31:0] tcnt, ts_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            ts_q <= '0;
        end else begin
            tcnt <= tcnt + 32'd1;
            if (status_q == '0 && status_nxt != '0) ts_q <= tcnt;
        end
    end
    assign bus.ts_first = ts_q;
`else
    assign bus.ts_first = 32'h0;
`endif

    assign bus.gpio_tri_i = {bus.gpio_tri_o[17:13], filt};
    assign bus.status     = status_q;
    assign bus.irq        = irq_q;
endmodule

// File: tb/tb_adrv9001_gpio_in_capture.sv
// tb_adrv9001_gpio_in_capture: random and directed stimulus on a debounced and a bypass instance, checked against a windowed-history model.
module tb_adrv9001_gpio_in_capture;
    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    adrv9001_gpio_in_capture_if b0 ();
    adrv9001_gpio_in_capture_if b1 ();

    assign b1.dgpio_in   = b0.dgpio_in;
    assign b1.irq_in     = b0.irq_in;
    assign b1.gpio_tri_o = b0.gpio_tri_o;
    assign b1.rise_mask  = b0.rise_mask;
    assign b1.fall_mask  = b0.fall_mask;
    assign b1.status_clr = b0.status_clr;

    adrv9001_gpio_in_capture #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_deb (.clk(clk), .rst(rst), .bus(b0));
    adrv9001_gpio_in_capture #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) dut_byp (.clk(clk), .rst(rst), .bus(b1));

    // syn_q[j] is the synchronized pad value j+1 edges ago; filt flips once the last d of them all disagree with it
    typedef struct packed {
        logic [S-1:0][12:0] pad_q;
        logic [3:0][12:0]   syn_q;
        logic [12:0]        filt;
        logic [12:0]        filt_d;
        logic [12:0]        status;
        logic               irq;
        logic [31:0]        tcnt;
        logic [31:0]        ts;
    } model_t;

    model_t m0 = '0;
    model_t m1 = '0;

    function automatic model_t step(model_t m, int d, logic [12:0] pad, logic [12:0] rm, logic [12:0] fm, logic [12:0] clr);
        model_t      n = m;
        logic [12:0] stable = '1;
        logic [12:0] syn_new;
        n.pad_q = {m.pad_q[S-2:0], pad};
        syn_new = n.pad_q[S-1];
        for (int j = 0; j < d; j++) stable &= m.syn_q[j] ^ m.filt;
        n.filt   = (d == 0) ? syn_new : m.filt ^ stable;
        n.syn_q  = {m.syn_q[2:0], syn_new};
        n.filt_d = m.filt;
        n.status = (m.status & ~clr) | (m.filt & ~m.filt_d & rm) | (~m.filt & m.filt_d & fm);
        n.irq    = |m.status;
        n.tcnt   = m.tcnt + 32'd1;
        n.ts     = (m.status == '0 && n.status != '0) ? m.tcnt : m.ts;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input string tag, input logic [17:0] gti, input logic [12:0] st, input logic ir, input logic [31:0] ts, input model_t m);
        chk({tag, ".gpio_tri_i"}, 32'(gti), 32'({b0.gpio_tri_o[17:13], m.filt}));
        chk({tag, ".status"}, 32'(st), 32'(m.status));
        chk({tag, ".irq"}, 32'(ir), 32'(m.irq));
`ifdef PIN_IRQ_TIMESTAMP_EN
        chk({tag, ".ts_first"}, ts, m.ts);
`else
        chk({tag, ".ts_first"}, ts, 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = step(m0, D, {b0.irq_in, b0.dgpio_in}, b0.rise_mask, b0.fall_mask, b0.status_clr);
            m1 = step(m1, 0, {b0.irq_in, b0.dgpio_in}, b0.rise_mask, b0.fall_mask, b0.status_clr);
        end
        #1;
        check_inst("deb", b0.gpio_tri_i, b0.status, b0.irq, b0.ts_first, m0);
        check_inst("byp", b1.gpio_tri_i, b1.status, b1.irq, b1.ts_first, m1);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pad_bit(input int b, input logic v);
        logic [12:0] p;
        p        = {b0.irq_in, b0.dgpio_in};
        p[b]     = v;
        {b0.irq_in, b0.dgpio_in} = p;
    endtask

    initial begin
        b0.dgpio_in   = 12'hFFF;
        b0.irq_in     = 1'b1;
        b0.gpio_tri_o = '0;
        b0.rise_mask  = '0;
        b0.fall_mask  = '0;
        b0.status_clr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gpio_tri_i", 32'(b0.gpio_tri_i[12:0]), 32'h0);
        chk("rst.status", 32'(b0.status), 32'h0);
        chk("rst.irq", 32'(b0.irq), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t1.deb_latency", 32'(b0.gpio_tri_i[12:0]), i >= 6 ? 32'h1FFF : 32'h0);
            chk("t1.byp_latency", 32'(b1.gpio_tri_i[12:0]), i >= 2 ? 32'h1FFF : 32'h0);
        end
        hold(3);
        chk("t1.no_status", 32'(b0.status), 32'h0);
        b0.dgpio_in = '0;
        b0.irq_in   = 1'b0;
        b0.rise_mask = '1;
        b0.fall_mask = '1;
        hold(10);
        chk("t1.fall_status", 32'(b0.status), 32'h1FFF);
        b0.status_clr = '1;
        tick();
        b0.status_clr = '0;
        hold(3);
        chk("clr.irq", 32'(b0.irq), 32'h0);
        pad_bit(3, 1'b1);
        hold(3);
        pad_bit(3, 1'b0);
        hold(8);
        chk("t2.glitch", 32'(b0.status[3]), 32'h0);
        pad_bit(3, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) pad_bit(3, 1'b0);
            tick();
            chk("t2.edge6", 32'(b0.gpio_tri_i[3]), (i >= 6) ? 32'h1 : 32'h0);
            chk("t2.status7", 32'(b0.status[3]), (i >= 7) ? 32'h1 : 32'h0);
            chk("t2.irq8", 32'(b0.irq), (i >= 8) ? 32'h1 : 32'h0);
        end
        hold(6);
        b0.gpio_tri_o = {5'b10110, 13'h0};
        #1;
        chk("t4.readback", 32'(b0.gpio_tri_i[17:13]), 32'h16);
        b0.irq_in = 1'b1;
        hold(10);
        b0.irq_in = 1'b0;
        hold(10);
        chk("t4.irq_status", 32'(b0.status[12]), 32'h1);
        b0.status_clr = '1;
        tick();
        b0.status_clr = '0;
        for (int i = 0; i < 1500; i++) begin
            logic [12:0] flip;
            flip = '0;
            for (int b = 0; b < 13; b++) flip[b] = ($urandom_range(4) == 0);
            {b0.irq_in, b0.dgpio_in} = {b0.irq_in, b0.dgpio_in} ^ flip;
            if ($urandom_range(40) == 0) begin
                b0.rise_mask = 13'($urandom);
                b0.fall_mask = 13'($urandom);
            end
            b0.status_clr = ($urandom_range(7) == 0) ? 13'($urandom) : 13'h0;
            if ($urandom_range(15) == 0) b0.gpio_tri_o = 18'($urandom);
            if (i == 700) begin
                rst = 1'b1;
                #1;
                chk("mid_rst.gpio_tri_i", 32'(b0.gpio_tri_i[12:0]), 32'h0);
                chk("mid_rst.status", 32'(b0.status), 32'h0);
                chk("mid_rst.irq", 32'(b0.irq), 32'h0);
                hold(2);
                rst = 1'b0;
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
